control: RTL and testbench

// - RV32I main decoder for the single-issue core; sits between instruction fetch and datapath.
// - Decodes a 32-bit instruction into the ALU operation and datapath mux/write-enable controls.
// - Outputs are registered: one clock of latency, giving a clean pipeline boundary into execute.

---
 rtl/control.sv | 172 +++++++++++++++++
 tb/tb_control.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/control.sv
// RV32I main decoder: combinational decode of i_Instr, registered outputs (1-cycle latency).
// Optional CONTROL_ILLEGAL_EN adds a registered o_Illegal flag for unsupported encodings.
module control (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [31:0] i_Instr,
  output logic [3:0]  o_ALUctl,
  output logic        o_Branch,
  output logic        o_MemToReg,
  output logic        o_MemWrite,
  output logic        o_ALUsrc,
`ifdef CONTROL_ILLEGAL_EN
  output logic        o_RegWrite,
  output logic        o_Illegal
`else
  output logic        o_RegWrite
`endif
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111
  } opcode_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = i_Instr[6:0];
  assign funct3 = i_Instr[14:12];
  assign funct7 = i_Instr[31:25];

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^{i_Instr[24:15], i_Instr[11:7]};

  alu_op_e    alu_d;
  logic       branch_d, memtoreg_d, memwrite_d, alusrc_d, regwrite_d, illegal_d;

  // Shared funct3 -> ALU mapping for R-type and I-type arithmetic.
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    alu_d      = ALU_ADD;
    branch_d   = 1'b0;
    memtoreg_d = 1'b0;
    memwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    regwrite_d = 1'b0;
    illegal_d  = 1'b0;

    case (opcode)
      OP_R: begin
        regwrite_d = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_d = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_d = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_d = ALU_SRA;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_I: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        alu_d      = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          illegal_d = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       alu_d = ALU_SRA;
          else if (funct7 != F7_BASE) illegal_d = 1'b1;
        end
      end
      OP_LOAD: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        memtoreg_d = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal_d = 1'b1;
      end
      OP_STORE: begin
        memwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        if (funct3[2] || funct3 == 3'b011) illegal_d = 1'b1;
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        case (funct3[2:1])
          2'b00:   alu_d = ALU_SUB;
          2'b10:   alu_d = ALU_SLT;
          2'b11:   alu_d = ALU_SLTU;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_LUI: begin
        regwrite_d = 1'b1;
        alusrc_d   = 1'b1;
        alu_d      = ALU_PASSB;
      end
      default: illegal_d = 1'b1;
    endcase

    // Illegal encodings collapse to a NOP so no architectural state is written.
    if (illegal_d) begin
      alu_d      = ALU_ADD;
      branch_d   = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      regwrite_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_ALUctl   <= '0;
      o_Branch   <= 1'b0;
      o_MemToReg <= 1'b0;
      o_MemWrite <= 1'b0;
      o_ALUsrc   <= 1'b0;
      o_RegWrite <= 1'b0;
    end else begin
      o_ALUctl   <= alu_d;
      o_Branch   <= branch_d;
      o_MemToReg <= memtoreg_d;
      o_MemWrite <= memwrite_d;
      o_ALUsrc   <= alusrc_d;
      o_RegWrite <= regwrite_d;
    end
  end

`ifdef CONTROL_ILLEGAL_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) o_Illegal <= 1'b0;
    else       o_Illegal <= illegal_d;
  end
`endif

endmodule

// File: tb/tb_control.sv
// Directed bench for the control decoder; outputs are checked as
// {ALUctl, Branch, MemToReg, MemWrite, ALUsrc, RegWrite}.
module tb_control;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [3:0]  alu;
  logic        branch, memtoreg, memwrite, alusrc, regwrite;
`ifdef CONTROL_ILLEGAL_EN
  logic        illegal;
`endif

  int unsigned passed;
  int unsigned total;

  control dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Instr    (instr),
    .o_ALUctl   (alu),
    .o_Branch   (branch),
    .o_MemToReg (memtoreg),
    .o_MemWrite (memwrite),
    .o_ALUsrc   (alusrc),
`ifdef CONTROL_ILLEGAL_EN
    .o_RegWrite (regwrite),
    .o_Illegal  (illegal)
`else
    .o_RegWrite (regwrite)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    outs = {alu, branch, memtoreg, memwrite, alusrc, regwrite};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_ill(input string tag, input logic exp_ill);
`ifdef CONTROL_ILLEGAL_EN
    total++;
    assert (illegal === exp_ill) passed++;
    else $error("FAIL %s_illegal observed=%b expected=%b", tag, illegal, exp_ill);
`else
    if (exp_ill === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [31:0] ins,
                      input logic [8:0] exp, input logic exp_ill);
    @(negedge clk);
    instr = ins;
    @(posedge clk);
    #1;
    check(tag, outs(), exp);
    check_ill(tag, exp_ill);
  endtask

  localparam logic [8:0] NOP = 9'b0000_00000;

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    instr  = '0;
    #2;
    check("reset_initial", outs(), NOP);
    check_ill("reset_initial", 1'b0);

    // Reset held across an edge with a valid instruction present.
    @(negedge clk);
    instr = {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011};
    @(posedge clk);
    #1;
    check("reset_held", outs(), NOP);
    @(negedge clk);
    rst = 1'b0;

    // R-type
    step("add",  {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011}, 9'b0000_00001, 1'b0);
    step("sub",  {7'b0100000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011}, 9'b0001_00001, 1'b0);
    step("sra",  {7'b0100000, 5'd1, 5'd2, 3'b101, 5'd3, 7'b0110011}, 9'b0111_00001, 1'b0);
    step("sll",  {7'b0000000, 5'd1, 5'd2, 3'b001, 5'd3, 7'b0110011}, 9'b0010_00001, 1'b0);
    step("sltu", {7'b0000000, 5'd1, 5'd2, 3'b011, 5'd3, 7'b0110011}, 9'b0100_00001, 1'b0);
    step("srl",  {7'b0000000, 5'd1, 5'd2, 3'b101, 5'd3, 7'b0110011}, 9'b0110_00001, 1'b0);
    step("or",   {7'b0000000, 5'd1, 5'd2, 3'b110, 5'd3, 7'b0110011}, 9'b1000_00001, 1'b0);
    step("and",  {7'b0000000, 5'd1, 5'd2, 3'b111, 5'd3, 7'b0110011}, 9'b1001_00001, 1'b0);

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", outs(), NOP);
    check_ill("reset_async", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // I-type ALU
    step("addi", {12'hFFF, 5'd2, 3'b000, 5'd3, 7'b0010011}, 9'b0000_00011, 1'b0);
    step("xori", {12'h0F0, 5'd2, 3'b100, 5'd3, 7'b0010011}, 9'b0101_00011, 1'b0);
    step("slti", {12'h800, 5'd2, 3'b010, 5'd3, 7'b0010011}, 9'b0011_00011, 1'b0);
    step("srai", {7'b0100000, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0010011}, 9'b0111_00011, 1'b0);
    step("srli", {7'b0000000, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0010011}, 9'b0110_00011, 1'b0);
    step("slli", {7'b0000000, 5'd4, 5'd2, 3'b001, 5'd3, 7'b0010011}, 9'b0010_00011, 1'b0);
    step("slli_bad_f7", {7'b0100000, 5'd4, 5'd2, 3'b001, 5'd3, 7'b0010011}, NOP, 1'b1);
    step("srli_bad_f7", {7'b0000001, 5'd4, 5'd2, 3'b101, 5'd3, 7'b0010011}, NOP, 1'b1);

    // Loads / stores
    step("lw",   {12'h004, 5'd2, 3'b010, 5'd3, 7'b0000011}, 9'b0000_01011, 1'b0);
    step("lbu",  {12'h004, 5'd2, 3'b100, 5'd3, 7'b0000011}, 9'b0000_01011, 1'b0);
    step("ld_bad", {12'h004, 5'd2, 3'b011, 5'd3, 7'b0000011}, NOP, 1'b1);
    step("sw",   {7'b0000000, 5'd1, 5'd2, 3'b010, 5'd4, 7'b0100011}, 9'b0000_00110, 1'b0);
    step("sb",   {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd4, 7'b0100011}, 9'b0000_00110, 1'b0);
    step("st_bad", {7'b0000000, 5'd1, 5'd2, 3'b100, 5'd4, 7'b0100011}, NOP, 1'b1);

    // Branches
    step("beq",  {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd8, 7'b1100011}, 9'b0001_10000, 1'b0);
    step("blt",  {7'b0000000, 5'd1, 5'd2, 3'b100, 5'd8, 7'b1100011}, 9'b0011_10000, 1'b0);
    step("bgeu", {7'b0000000, 5'd1, 5'd2, 3'b111, 5'd8, 7'b1100011}, 9'b0100_10000, 1'b0);
    step("br_bad", {7'b0000000, 5'd1, 5'd2, 3'b010, 5'd8, 7'b1100011}, NOP, 1'b1);

    // LUI and illegal encodings
    step("lui",  {20'h12345, 5'd5, 7'b0110111}, 9'b1010_00011, 1'b0);
    step("op_bad", {25'h0, 7'b1111111}, NOP, 1'b1);
    step("r_bad_f7", {7'b0100000, 5'd1, 5'd2, 3'b001, 5'd3, 7'b0110011}, NOP, 1'b1);
    step("low_bits", {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110010}, NOP, 1'b1);
    step("after_bad", {7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3, 7'b0110011}, 9'b0000_00001, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
